// File: rtl/cache_pkg.sv
// Shared types, geometry constants and address-slicing helpers for the cache controller.
package cache_pkg;

   localparam int unsigned CACHE_ADDR_W   = 16;
   localparam int unsigned CACHE_DATA_W   = 8;
   localparam int unsigned CACHE_INDEX_W  = 3;
   localparam int unsigned CACHE_OFFSET_W = 5;

   localparam int unsigned TAG_W      = CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W;
   localparam int unsigned LINES      = 1 << CACHE_INDEX_W;
   localparam int unsigned LINE_BYTES = 1 << CACHE_OFFSET_W;

   // Controller states, kept as plain constants so legacy tools can consume them
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_COMPARE = 3'd1;
   localparam state_t S_WB      = 3'd2;
   localparam state_t S_FILL    = 3'd3;
   localparam state_t S_DONE    = 3'd4;

   function automatic logic [TAG_W-1:0] get_tag(input logic [CACHE_ADDR_W-1:0] a);
      return a[CACHE_ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [CACHE_INDEX_W-1:0] get_idx(input logic [CACHE_ADDR_W-1:0] a);
      return a[CACHE_OFFSET_W +: CACHE_INDEX_W];
   endfunction

   function automatic logic [CACHE_OFFSET_W-1:0] get_off(input logic [CACHE_ADDR_W-1:0] a);
      return a[CACHE_OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU-side request bus and byte-serial SDRAM handshake of the cache controller.
// slave: the cache controller; master: the CPU/SDRAM environment driving it.
interface cache_controller_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8
);
   logic              cs;
   logic              wr_rd;
   logic [ADDR_W-1:0] add;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              rdy;
   logic              mem_strb;
   logic              mem_wr_rd;
   logic [ADDR_W-1:0] mem_add;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport slave (
      input  cs, wr_rd, add, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, rdy, mem_strb, mem_wr_rd, mem_add, mem_wdata
   );

   modport master (
      output cs, wr_rd, add, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, rdy, mem_strb, mem_wr_rd, mem_add, mem_wdata
   );
endinterface

// File: rtl/cache_line_store.sv
// Line storage: 8 x 32-byte data array with one read/write port, plus per-line tag,
// valid and dirty. Only valid/dirty are cleared by i_clr_n; data and tags are not reset.
module cache_line_store
   import cache_pkg::*;
(
   input  logic                      i_clk,
   input  logic                      i_clr_n,
   input  logic [CACHE_INDEX_W-1:0]  i_idx,
   input  logic [CACHE_OFFSET_W-1:0] i_off,
   input  logic                      i_data_we,
   input  logic [CACHE_DATA_W-1:0]   i_data_wdata,
   output logic [CACHE_DATA_W-1:0]   o_data_rdata,
   input  logic                      i_tag_we,
   input  logic [TAG_W-1:0]          i_tag_wdata,
   input  logic                      i_dirty_set,
   input  logic                      i_dirty_clr,
   output logic [TAG_W-1:0]          o_tag,
   output logic                      o_valid,
   output logic                      o_dirty
);

   logic [CACHE_DATA_W-1:0] r_data [LINES*LINE_BYTES];
   logic [TAG_W-1:0]        r_tag  [LINES];
   logic [LINES-1:0]        r_valid;
   logic [LINES-1:0]        r_dirty;
   logic [CACHE_INDEX_W+CACHE_OFFSET_W-1:0] w_addr;

   assign w_addr       = {i_idx, i_off};
   assign o_data_rdata = r_data[w_addr];
   assign o_tag        = r_tag[i_idx];
   assign o_valid      = r_valid[i_idx];
   assign o_dirty      = r_dirty[i_idx];

   // Data array write port
   always_ff @(posedge i_clk) begin
      if (i_data_we) begin
         r_data[w_addr] <= i_data_wdata;
      end
   end

   // Tag is written once the fill of a line completes
   always_ff @(posedge i_clk) begin
      if (i_tag_we) begin
         r_tag[i_idx] <= i_tag_wdata;
      end
   end

   // Valid/dirty bits, cleared together so an aborted fill leaves the line invalid
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         if (i_tag_we) begin
            r_valid[i_idx] <= 1'b1;
         end
         if (i_dirty_set) begin
            r_dirty[i_idx] <= 1'b1;
         end else if (i_dirty_clr) begin
            r_dirty[i_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with a byte-serial
// strobe/ack SDRAM interface. Optional CACHE_STATS_EN adds saturating hit/miss counters.
// Parameters must agree with the geometry constants in cache_pkg.
module cache_controller #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned INDEX_W  = 3,
   parameter int unsigned OFFSET_W = 5
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   cache_controller_if.slave  io_bus
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]        o_hit_cnt,
   output logic [15:0]        o_miss_cnt
`endif
);
   import cache_pkg::*;

   state_t              r_state;
   logic                r_cs_q;
   logic                r_req_wr;
   logic [ADDR_W-1:0]   r_req_add;
   logic [DATA_W-1:0]   r_req_wdata;
   logic [OFFSET_W-1:0] r_cnt;
   logic                r_rdy;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic                r_mem_strb;
   logic                r_mem_wr_rd;
   logic [ADDR_W-1:0]   r_mem_add;
   logic [DATA_W-1:0]   r_mem_wdata;

   logic [TAG_W-1:0]    w_req_tag;
   logic [INDEX_W-1:0]  w_req_idx;
   logic [OFFSET_W-1:0] w_req_off;
   logic [TAG_W-1:0]    w_line_tag;
   logic                w_line_valid;
   logic                w_line_dirty;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_accept;
   logic                w_ack;
   logic                w_last;
   logic                w_hit;
   logic [OFFSET_W-1:0] w_off;
   logic                w_data_we;
   logic [DATA_W-1:0]   w_data_wdata;
   logic                w_tag_we;
   logic                w_dirty_set;
   logic                w_dirty_clr;

   assign w_req_tag = get_tag(r_req_add);
   assign w_req_idx = get_idx(r_req_add);
   assign w_req_off = get_off(r_req_add);

   // Only a rising edge of cs in IDLE starts a request; a held cs never re-triggers
   assign w_accept = (r_state == S_IDLE) && io_bus.cs && !r_cs_q;
   // An ack only counts while our strobe is out
   assign w_ack    = r_mem_strb && io_bus.mem_ack;
   assign w_last   = (r_cnt == {OFFSET_W{1'b1}});
   assign w_hit    = w_line_valid && (w_line_tag == w_req_tag);

   // Line-store port control: byte counter during bursts, request offset otherwise
   always_comb begin
      w_off        = w_req_off;
      w_data_we    = 1'b0;
      w_data_wdata = r_req_wdata;
      w_tag_we     = 1'b0;
      w_dirty_set  = 1'b0;
      w_dirty_clr  = 1'b0;
      case (r_state)
         S_WB: begin
            w_off       = r_cnt;
            w_dirty_clr = w_ack && w_last;
         end
         S_FILL: begin
            w_off        = r_cnt;
            w_data_we    = w_ack;
            w_data_wdata = io_bus.mem_rdata;
            w_tag_we     = w_ack && w_last;
         end
         S_DONE: begin
            w_data_we   = r_req_wr;
            w_dirty_set = r_req_wr;
         end
         default: ;
      endcase
   end

   cache_line_store u_store (
      .i_clk        (i_clk),
      .i_clr_n      (i_rst_n),
      .i_idx        (w_req_idx),
      .i_off        (w_off),
      .i_data_we    (w_data_we),
      .i_data_wdata (w_data_wdata),
      .o_data_rdata (w_rdata),
      .i_tag_we     (w_tag_we),
      .i_tag_wdata  (w_req_tag),
      .i_dirty_set  (w_dirty_set),
      .i_dirty_clr  (w_dirty_clr),
      .o_tag        (w_line_tag),
      .o_valid      (w_line_valid),
      .o_dirty      (w_line_dirty)
   );

   // Main FSM: request capture, tag compare, writeback/fill bursts and completion
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cs_q      <= 1'b0;
         r_req_wr    <= 1'b0;
         r_req_add   <= '0;
         r_req_wdata <= '0;
         r_cnt       <= '0;
         r_rdy       <= 1'b1;
         r_cpu_rdata <= '0;
         r_mem_strb  <= 1'b0;
         r_mem_wr_rd <= 1'b0;
         r_mem_add   <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_cs_q <= io_bus.cs;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_req_add   <= io_bus.add;
                  r_req_wr    <= io_bus.wr_rd;
                  r_req_wdata <= io_bus.cpu_wdata;
                  r_rdy       <= 1'b0;
                  r_state     <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               r_cnt <= '0;
               if (w_hit) begin
                  r_state <= S_DONE;
               end else if (w_line_dirty) begin
                  r_state <= S_WB;
               end else begin
                  r_state <= S_FILL;
               end
            end
            S_WB: begin
               // Strobe drops on the ack edge, giving at least one idle cycle per byte
               if (w_ack) begin
                  r_mem_strb <= 1'b0;
                  r_cnt      <= r_cnt + OFFSET_W'(1);
                  if (w_last) begin
                     r_state <= S_FILL;
                  end
               end else if (!r_mem_strb) begin
                  r_mem_strb  <= 1'b1;
                  r_mem_wr_rd <= 1'b1;
                  r_mem_add   <= {w_line_tag, w_req_idx, r_cnt};
                  r_mem_wdata <= w_rdata;
               end
            end
            S_FILL: begin
               if (w_ack) begin
                  r_mem_strb <= 1'b0;
                  r_cnt      <= r_cnt + OFFSET_W'(1);
                  if (w_last) begin
                     r_state <= S_DONE;
                  end
               end else if (!r_mem_strb) begin
                  r_mem_strb  <= 1'b1;
                  r_mem_wr_rd <= 1'b0;
                  r_mem_add   <= {w_req_tag, w_req_idx, r_cnt};
               end
            end
            S_DONE: begin
               if (!r_req_wr) begin
                  r_cpu_rdata <= w_rdata;
               end
               r_rdy   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_rdy   <= 1'b1;
            end
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] r_hit_cnt;
   logic [15:0] r_miss_cnt;

   // Saturating hit/miss counters, one event per tag compare
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == S_COMPARE) begin
         if (w_hit) begin
            if (r_hit_cnt != 16'hFFFF) begin
               r_hit_cnt <= r_hit_cnt + 16'd1;
            end
         end else if (r_miss_cnt != 16'hFFFF) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
         end
      end
   end

   assign o_hit_cnt  = r_hit_cnt;
   assign o_miss_cnt = r_miss_cnt;
`endif

   assign io_bus.rdy       = r_rdy;
   assign io_bus.cpu_rdata = r_cpu_rdata;
   assign io_bus.mem_strb  = r_mem_strb;
   assign io_bus.mem_wr_rd = r_mem_wr_rd;
   assign io_bus.mem_add   = r_mem_add;
   assign io_bus.mem_wdata = r_mem_wdata;

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller that sits directly downstream of the CPU stimulus block.
- Consumes its cs/wr_rd/add/dout bus and returns data and rdy.
- Holds an internal 8-line x 32-byte data array plus tag, valid and dirty arrays.
- Services misses through a byte-serial strobe/ack handshake to the SDRAM model.

Parameters:
- ADDR_W, 16, CPU/SDRAM address width.
- DATA_W, 8, data width.
- INDEX_W, 3, line index bits (8 lines).
- OFFSET_W, 5, byte offset bits (32-byte lines).
- TAG_W is derived as ADDR_W-INDEX_W-OFFSET_W (= 8); it is a localparam, not a parameter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- cs  in  1  CPU request strobe; may be held high for several cycles.
- wr_rd  in  1  1 = write, 0 = read; sampled with add at request acceptance.
- add  in  ADDR_W  CPU byte address: tag = [15:8], index = [7:5], offset = [4:0].
- cpu_wdata  in  DATA_W  CPU write data (CPU's dout).
- cpu_rdata  out  DATA_W  read data to CPU (CPU's din).
- rdy  out  1  1 = idle, ready to accept a request.
- mem_strb  out  1  SDRAM byte-transfer request.
- mem_wr_rd  out  1  1 = SDRAM write, 0 = SDRAM read.
- mem_add  out  ADDR_W  SDRAM byte address.
- mem_wdata  out  DATA_W  SDRAM write data.
- mem_rdata  in  DATA_W  SDRAM read data, valid while mem_ack = 1.
- mem_ack  in  1  one-cycle completion pulse for the current byte.

Behaviour:
- Reset values (rst = 0, asynchronous):
  - state IDLE; rdy = 1.
  - cpu_rdata, mem_strb, mem_wr_rd, mem_add, mem_wdata = 0.
  - All valid and dirty bits = 0; byte counter = 0; cs_q = 0.
  - The data and tag arrays are not reset.
- Reset mid-operation aborts any fill or writeback immediately. The partial line stays invalid because valid is cleared.
- Request acceptance: only in IDLE, and only on a cs rising edge (cs = 1, cs_q = 0).
  - A cs level held through completion must never re-trigger a request.
  - At acceptance, latch add, wr_rd and cpu_wdata; rdy drops to 0 on the next edge.
- COMPARE (1 cycle): hit = valid[idx] && tag[idx] == req_tag.
  - Hit: go to DONE.
  - Miss with dirty[idx] = 1: go to WB.
  - Miss with dirty[idx] = 0: go to FILL.
- WB: 32 sequential byte writes, offset 0..31.
  - mem_add = {tag[idx], idx, cnt}; mem_wdata = line byte cnt; mem_wr_rd = 1.
  - mem_strb stays 1 until mem_ack.
  - On mem_ack, cnt++. After the ack for cnt = 31, set cnt = 0, clear dirty, go to FILL.
- FILL: 32 sequential byte reads, mem_add = {req_tag, idx, cnt}; mem_wr_rd = 0.
  - On mem_ack, store mem_rdata into byte cnt.
  - After the ack for cnt = 31: set tag = req_tag, valid = 1, go to DONE.
- mem_strb drops to 0 for at least one cycle between bytes. Only one transfer is outstanding at a time.
- mem_ack outside WB/FILL is ignored.
- DONE (1 cycle):
  - Read: cpu_rdata = line[idx][off].
  - Write: line[idx][off] = wdata and dirty[idx] = 1.
  - Then rdy = 1 and return to IDLE.
- cpu_rdata holds its value until the next read completes.
- Latency from accept edge to rdy = 1: hit 3 cycles. A miss adds 32 (fill) or 64 (writeback + fill) handshakes.
- The CPU's 4-cycle cs pulse overlaps hit completion. The rising-edge rule prevents a double issue.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: add output ports hit_cnt [15:0] and miss_cnt [15:0], both reset to 0.
  - Each increments by one in COMPARE and saturates at 0xFFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - typedef state_t {IDLE, COMPARE, WB, FILL, DONE};
  - localparams TAG_W, LINES, LINE_BYTES;
  - helper functions get_tag, get_idx, get_off.
- One sub-module, cache_line_store: data array with a single read/write port, plus tag/valid/dirty arrays with a clear-all-on-reset input.

Test Plan:
- After reset, a cs rising edge with read 0x1234 → FILL reads 0x1220..0x123F (32 strobes, no WB). rdy returns 1; cpu_rdata = SDRAM byte at 0x1234.
- Write 0xAA to 0x1234 → hit, no mem_strb, rdy at 3 cycles; dirty[1] = 1.
- Read 0x1234 with cs held 4 cycles → cpu_rdata = 0xAA. Exactly one request is processed and no second rdy drop occurs.
- Read 0xFF34 → WB of 32 writes to 0x1220..0x123F, with the byte at 0x1234 = 0xAA. Then FILL 0xFF20..0xFF3F; tag[1] = 0xFF; dirty[1] = 0.
- Write miss to 0x5660 from a clean state → fill 0x5660..0x567F, then byte 0 written. A following read of 0x5660 hits and returns the written byte.
- rst pulsed low at FILL byte 10 of read 0x1234 → mem_strb = 0 and rdy = 1 immediately. Re-reading 0x1234 misses with a full 32-byte fill. With CACHE_STATS_EN, hit_cnt and miss_cnt are 0 after reset.
